// File: rtl/sqrt_datapath.sv
// Integer square-root datapath driven by an external controller (odd-number summation method).
// Latency: one register stage per enable; greater is combinational from current registers.
// Backpressure: none; the controller sequences load, accumulate-until-greater, then output.
//
// Ports:
//   clk, clr_n        - clock, synchronous active-low reset
//   din               - radicand (WIDTH bits)
//   en_a/en_del/en_sq - register enables for radicand / delta / square
//   en_out            - captures root and raises done
//   ld_add            - 0 = load initial values, 1 = accumulate
//   greater           - sq_reg > a_reg (combinational status)
//   root, done, iter  - registered result, valid flag, accumulate count
module sqrt_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               en_a,
  input  logic               en_del,
  input  logic               en_sq,
  input  logic               en_out,
  input  logic               ld_add,
  output logic               greater,
  output logic [WIDTH/2-1:0] root,
  output logic               done,
  output logic [WIDTH/2:0]   iter
);

  localparam int HW = WIDTH / 2;
  localparam int SW = WIDTH + 1;   // square register holds up to (2^HW)^2
  localparam int DW = HW + 2;      // delta register holds up to 2^(HW+1)+1

  logic [WIDTH-1:0] a_reg;
  logic [SW-1:0]    sq_reg;
  logic [DW-1:0]    del_reg;

  logic [SW-1:0]    sq_sum;
  logic [DW-1:0]    del_sum;
  logic [DW-1:0]    del_half;

  // Both sums use the pre-edge delta so square and delta advance in lockstep.
  assign sq_sum   = sq_reg + SW'(del_reg);
  assign del_sum  = del_reg + DW'(2);
  // delta = 2k+3 after k accumulates, so (delta>>1)-1 = k+1-1 recovers the root.
  assign del_half = (del_reg >> 1) - DW'(1);

  assign greater = sq_reg > {1'b0, a_reg};

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      a_reg   <= '0;
      sq_reg  <= '0;
      del_reg <= '0;
      root    <= '0;
      iter    <= '0;
      done    <= 1'b0;
    end else begin
      // Radicand is captured only on load so din may change while iterating.
      if (en_a && !ld_add)
        a_reg <= din;

      if (en_sq)
        sq_reg <= ld_add ? sq_sum : SW'(1);

      if (en_del)
        del_reg <= ld_add ? del_sum : DW'(3);

      if (en_sq && !ld_add) begin
        iter <= '0;
        done <= 1'b0;
      end else if (en_sq && ld_add && (iter != '1)) begin
        iter <= iter + 1'b1;
      end

      // Placed last so a coincident en_out still raises done.
      if (en_out) begin
        root <= del_half[HW-1:0];
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_datapath.sv
module tb_sqrt_datapath;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             clr_n;
  logic [WIDTH-1:0] din;
  logic             en_a, en_del, en_sq, en_out, ld_add;
  logic             greater;
  logic [3:0]       root;
  logic             done;
  logic [4:0]       iter;

  int checks = 0;
  int failures = 0;

  sqrt_datapath #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clr_n(clr_n), .din(din),
    .en_a(en_a), .en_del(en_del), .en_sq(en_sq), .en_out(en_out), .ld_add(ld_add),
    .greater(greater), .root(root), .done(done), .iter(iter)
  );

  always #5 clk = ~clk;

  typedef struct {
    int din;
    int exp_root;
    int exp_iter;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic a, input logic d, input logic s,
                         input logic o, input logic l);
    en_a = a; en_del = d; en_sq = s; en_out = o; ld_add = l;
  endtask

  // Full controller sequence; din_acc is presented on din while accumulating.
  task automatic run_op(input int d, input int din_acc, output int acc_cnt);
    din = d[WIDTH-1:0];
    set_ctl(1, 1, 1, 0, 0);
    cyc();
    din = din_acc[WIDTH-1:0];
    acc_cnt = 0;
    while (!greater && acc_cnt < 40) begin
      set_ctl(1, 1, 1, 0, 1);
      cyc();
      acc_cnt++;
    end
    if (!greater) begin
      checks++;
      failures++;
      $display("FAIL timeout_greater: got greater=0 after %0d accumulates expected 1", acc_cnt);
    end
    set_ctl(0, 0, 0, 1, 0);
    cyc();
    set_ctl(0, 0, 0, 0, 0);
  endtask

  initial begin
    vec_t vecs[11];
    int   n;
    int   exp_r;
    logic [3:0] held_root;

    vecs[0]  = '{16, 4, 4};
    vecs[1]  = '{0, 0, 0};
    vecs[2]  = '{255, 15, 15};
    vecs[3]  = '{1, 1, 1};
    vecs[4]  = '{2, 1, 1};
    vecs[5]  = '{3, 1, 1};
    vecs[6]  = '{4, 2, 2};
    vecs[7]  = '{99, 9, 9};
    vecs[8]  = '{100, 10, 10};
    vecs[9]  = '{224, 14, 14};
    vecs[10] = '{225, 15, 15};

    // Reset with enables active: reset must win.
    clr_n = 1'b0;
    din = 8'd77;
    set_ctl(1, 1, 1, 1, 1);
    cyc();
    cyc();
    chk("rst_root", int'(root), 0);
    chk("rst_iter", int'(iter), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_greater", int'(greater), 0);
    clr_n = 1'b1;
    set_ctl(0, 0, 0, 0, 0);
    cyc();

    // din=0: greater straight after the load cycle.
    din = 8'd0;
    set_ctl(1, 1, 1, 0, 0);
    cyc();
    chk("zero_greater_after_load", int'(greater), 1);
    chk("zero_done_cleared", int'(done), 0);
    set_ctl(0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].din, vecs[i].din, n);
      chk($sformatf("vec%0d_root din=%0d", i, vecs[i].din), int'(root), vecs[i].exp_root);
      chk($sformatf("vec%0d_iter din=%0d", i, vecs[i].din), int'(iter), vecs[i].exp_iter);
      chk($sformatf("vec%0d_done din=%0d", i, vecs[i].din), int'(done), 1);
      chk($sformatf("vec%0d_acc din=%0d", i, vecs[i].din), n, vecs[i].exp_iter);
      if (vecs[i].din == 255) begin
        chk("max_sq_reg", int'(dut.sq_reg), 256);
        chk("max_del_reg", int'(dut.del_reg), 33);
      end
    end

    // Idle hold: nothing moves with all enables low.
    held_root = root;
    din = 8'd3;
    repeat (4) cyc();
    chk("idle_root_hold", int'(root), int'(held_root));
    chk("idle_iter_hold", int'(iter), 15);
    chk("idle_greater_hold", int'(greater), 1);
    chk("idle_done_hold", int'(done), 1);

    // din changes during accumulation must be ignored.
    run_op(15, 200, n);
    chk("dinchg_root", int'(root), 3);
    chk("dinchg_iter", int'(iter), 3);

    // Reset mid-operation, then a clean restart.
    din = 8'd100;
    set_ctl(1, 1, 1, 0, 0);
    cyc();
    repeat (5) begin
      set_ctl(1, 1, 1, 0, 1);
      cyc();
    end
    chk("midop_iter_before_rst", int'(iter), 5);
    clr_n = 1'b0;
    cyc();
    chk("midrst_root", int'(root), 0);
    chk("midrst_iter", int'(iter), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_greater", int'(greater), 0);
    clr_n = 1'b1;
    set_ctl(0, 0, 0, 0, 0);
    run_op(9, 9, n);
    chk("reload_root", int'(root), 3);
    chk("reload_iter", int'(iter), 3);

    // en_out coincident with an accumulate: root from pre-edge delta (7 -> 2).
    din = 8'd16;
    set_ctl(1, 1, 1, 0, 0);
    cyc();
    set_ctl(1, 1, 1, 0, 1);
    cyc();
    cyc();
    set_ctl(1, 1, 1, 1, 1);
    cyc();
    set_ctl(0, 0, 0, 0, 0);
    chk("coinc_root", int'(root), 2);
    chk("coinc_done", int'(done), 1);
    chk("coinc_iter", int'(iter), 3);

    // Exhaustive sweep against an integer square-root model.
    for (int d = 0; d < 256; d++) begin
      exp_r = 0;
      while ((exp_r + 1) * (exp_r + 1) <= d) exp_r++;
      run_op(d, d, n);
      chk($sformatf("sweep_root din=%0d", d), int'(root), exp_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
